// File: rtl/mbbmp_ctrl_pkg.sv
// mbbmp_pkg: shared definitions for the multi-depth bitmap scan-out controller.
//   - bpp_sel encodings and their log2 decode (reserved decodes as 1bpp)
//   - DATA_W: framebuffer data width (fixed at 8)
//   - slot_t: per-pixel pipeline slot (fresh read flag, pixel offset, depth, active)
//   - pal_reset(): reset value of palette entry i (identity ramp)
//   - expand_idx(): pixel extraction from a byte plus expansion to a 4-bit index
package mbbmp_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    BPP1     = 2'd0,
    BPP2     = 2'd1,
    BPP4     = 2'd2,
    BPP_RSVD = 2'd3
  } bpp_e;

  typedef struct packed {
    logic       fresh;
    logic [2:0] k;
    logic [1:0] b;
    logic       de;
  } slot_t;

  // Reserved encoding falls back to 1bpp so a bad setting still scans out.
  function automatic logic [1:0] bpp_log2(input logic [1:0] sel);
    case (bpp_e'(sel))
      BPP2:    return 2'd1;
      BPP4:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] pal_reset(input int i);
    return 32'(i);
  endfunction

  // Pixel k sits at dat[k*2^b +: 2^b] (LSB-first); narrow pixels are
  // replicated so 1bpp maps to 0/F and 2bpp to 0/5/A/F.
  function automatic logic [3:0] expand_idx(input logic [DATA_W-1:0] dat,
                                            input logic [2:0] k,
                                            input logic [1:0] b);
    logic [3:0]        shamt;
    logic [DATA_W-1:0] sh;
    shamt = {1'b0, k} << b;
    sh    = dat >> shamt;
    case (b)
      2'd0:    return {4{sh[0]}};
      2'd1:    return {2{sh[1:0]}};
      default: return sh[3:0];
    endcase
  endfunction

endpackage

// File: rtl/mbbmp_ctrl_if.sv
// mbbmp_ctrl_if: framebuffer read port between the controller and the RAM.
//   scr_addr : byte address (controller -> RAM)
//   rd_en    : read strobe for scr_addr (controller -> RAM)
//   val      : read data, valid MEM_LAT cycles after rd_en (RAM -> controller)
// Modports: master = controller side, slave = RAM side.
interface mbbmp_ctrl_if #(
  parameter int ADDR_W = 16
) ();
  import mbbmp_pkg::*;

  logic [ADDR_W-1:0] scr_addr;
  logic              rd_en;
  logic [DATA_W-1:0] val;

  modport master (output scr_addr, output rd_en, input val);
  modport slave  (input scr_addr, input rd_en, output val);

endinterface

// File: rtl/mbbmp_ctrl_palette.sv
// mbbmp_palette: 16-entry colour palette with one write port and a registered
// lookup that produces the final pixel colour.
//   clk, rst_n        : clock, asynchronous active-low reset (reset loads a ramp)
//   we, widx, wdata   : palette write; visible to lookups from the next cycle
//   lookup_de         : lookup slot is active video (inactive gives colour 0)
//   lookup_idx        : 4-bit palette index to look up
//   pixel             : registered colour output
module mbbmp_palette
  import mbbmp_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [3:0]       widx,
  input  logic [OUT_W-1:0] wdata,
  input  logic             lookup_de,
  input  logic [3:0]       lookup_idx,
  output logic [OUT_W-1:0] pixel
);

  logic [OUT_W-1:0] pal [16];

  // The lookup reads the array before this edge's write lands, so a
  // same-cycle write to the looked-up entry yields the old colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= OUT_W'(pal_reset(i));
      end
      pixel <= '0;
    end else begin
      if (we) begin
        pal[widx] <= wdata;
      end
      pixel <= lookup_de ? pal[lookup_idx] : '0;
    end
  end

endmodule

// File: rtl/mbbmp_ctrl.sv
// mbbmp_ctrl: multi-depth (1/2/4 bpp) bitmap scan-out controller.
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   posx, posy, de_in : raster position and active-video qualifier
//   bpp_sel           : colour depth, sampled with each pixel
//   fb (master)       : framebuffer read port (scr_addr, rd_en, val)
//   pal_we/idx/data   : palette write port
//   m_pixel, de_out   : colour output and aligned active flag, MEM_LAT+2 cycles
//                       after the raster inputs
module mbbmp_ctrl
  import mbbmp_pkg::*;
#(
  parameter int SCALE_SHIFT = 2,
  parameter int ROW_SHIFT   = 8,
  parameter int MEM_LAT     = 1,
  parameter int OUT_W       = 4,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        posx,
  input  logic [8:0]        posy,
  input  logic              de_in,
  input  logic [1:0]        bpp_sel,
  mbbmp_ctrl_if.master      fb,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [OUT_W-1:0]  pal_data,
  output logic [OUT_W-1:0]  m_pixel,
  output logic              de_out
);

  logic [1:0]        b0;
  logic [31:0]       col0;
  logic [31:0]       row0;
  logic [31:0]       byte_col0;
  logic [31:0]       addr_full;
  logic [2:0]        k0;
  logic [ADDR_W-1:0] addr0;
  logic              rd0;
  logic              last_valid;
  slot_t             s1;
  slot_t             dly [MEM_LAT];
  slot_t             cap;
  logic [DATA_W-1:0] byte_hold;
  logic [DATA_W-1:0] cur_byte;
  logic [3:0]        idx;

  // scr_addr only moves on active pixels, so it doubles as the last issued
  // address; a read is skipped when the byte is already held.
  always_comb begin
    b0        = bpp_log2(bpp_sel);
    col0      = 32'(posx) >> SCALE_SHIFT;
    row0      = 32'(posy) >> SCALE_SHIFT;
    byte_col0 = col0 >> (2'd3 - b0);
    k0        = col0[2:0] & (3'd7 >> b0);
    addr_full = (row0 << ROW_SHIFT) | byte_col0;
    addr0     = ADDR_W'(addr_full);
    rd0       = de_in && (!last_valid || (addr0 != fb.scr_addr));
  end

  // Dropping de_in forgets the last address so every line opens with a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb.scr_addr <= '0;
      fb.rd_en    <= 1'b0;
      last_valid  <= 1'b0;
      s1          <= '0;
    end else begin
      fb.rd_en <= rd0;
      s1       <= slot_t'{fresh: rd0, k: k0, b: b0, de: de_in};
      if (de_in) begin
        fb.scr_addr <= addr0;
        last_valid  <= 1'b1;
      end else begin
        last_valid  <= 1'b0;
      end
    end
  end

  // Slot delay line so each pixel's decode info meets its read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        dly[i] <= '0;
      end
    end else begin
      dly[0] <= s1;
      for (int i = 1; i < MEM_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign cap      = dly[MEM_LAT-1];
  assign cur_byte = cap.fresh ? fb.val : byte_hold;
  assign idx      = expand_idx(cur_byte, cap.k, cap.b);

  // Fresh slots refresh the held byte; later pixels of that byte reuse it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_hold <= '0;
      de_out    <= 1'b0;
    end else begin
      if (cap.fresh) begin
        byte_hold <= fb.val;
      end
      de_out <= cap.de;
    end
  end

  mbbmp_palette #(.OUT_W(OUT_W)) u_palette (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (pal_we),
    .widx       (pal_idx),
    .wdata      (pal_data),
    .lookup_de  (cap.de),
    .lookup_idx (idx),
    .pixel      (m_pixel)
  );

endmodule

// File: tb/tb_mbbmp_ctrl.sv
// tb_mbbmp_ctrl: self-checking bench for mbbmp_ctrl (MEM_LAT=1).
// A behavioural framebuffer answers reads after MEM_LAT cycles and drives
// random junk otherwise; a pixel-level model predicts every output each cycle,
// and directed sequences pin the model with hand-computed values.
module tb_mbbmp_ctrl;

  localparam int ML = 1;
  localparam int OW = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    posx;
  logic [8:0]    posy;
  logic          de_in;
  logic [1:0]    bpp_sel;
  logic          pal_we;
  logic [3:0]    pal_idx;
  logic [OW-1:0] pal_data;
  logic [OW-1:0] m_pixel;
  logic          de_out;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [7:0] mem [65536];

  mbbmp_ctrl_if #(.ADDR_W(AW)) fb ();

  mbbmp_ctrl #(
    .SCALE_SHIFT (2),
    .ROW_SHIFT   (8),
    .MEM_LAT     (ML),
    .OUT_W       (OW),
    .ADDR_W      (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .posx     (posx),
    .posy     (posy),
    .de_in    (de_in),
    .bpp_sel  (bpp_sel),
    .fb       (fb),
    .pal_we   (pal_we),
    .pal_idx  (pal_idx),
    .pal_data (pal_data),
    .m_pixel  (m_pixel),
    .de_out   (de_out)
  );

  always #5 clk = ~clk;

  // Framebuffer: requests seen mid-cycle answer MEM_LAT cycles later.
  logic          req_rd   [ML];
  logic [AW-1:0] req_addr [ML];

  always @(negedge clk) begin
    req_rd[0]   <= fb.rd_en;
    req_addr[0] <= fb.scr_addr;
    for (int i = 1; i < ML; i++) begin
      req_rd[i]   <= req_rd[i-1];
      req_addr[i] <= req_addr[i-1];
    end
  end

  always @(posedge clk) begin
    fb.val <= req_rd[ML-1] ? mem[req_addr[ML-1]] : 8'($urandom);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel-level model: address, pixel offset and colour from plain arithmetic.
  typedef struct {
    bit de;
    int addr;
    int b;
    int k;
  } ment_t;

  ment_t         mq[$];
  int            pal_m [16];
  int            m_addr;
  bit            m_lv;
  logic [3:0]    exp_pix;
  logic          exp_de;
  logic          exp_rd;
  logic [AW-1:0] exp_addr;

  function automatic int modelIndex(input int dat, input int b, input int k);
    int bits;
    int v;
    bits = 1 << b;
    v = (dat >> (k * bits)) % (1 << bits);
    if (b == 0) return v * 15;
    if (b == 1) return v * 5;
    return v;
  endfunction

  initial begin
    ment_t e;
    ment_t n;
    int    b;
    int    col;
    int    ppb;
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        mq.delete();
        for (int i = 0; i < ML + 1; i++) mq.push_back('{de: 1'b0, addr: 0, b: 0, k: 0});
        for (int i = 0; i < 16; i++) pal_m[i] = i;
        m_addr = 0; m_lv = 1'b0;
        exp_pix = 4'd0; exp_de = 1'b0; exp_rd = 1'b0; exp_addr = '0;
      end else begin
        e = mq.pop_front();
        exp_de  = e.de;
        exp_pix = e.de ? 4'(pal_m[modelIndex(int'(mem[e.addr]), e.b, e.k)]) : 4'd0;
        if (pal_we) pal_m[pal_idx] = int'(pal_data);
        b   = (bpp_sel == 2'd2) ? 2 : (bpp_sel == 2'd1) ? 1 : 0;
        ppb = 8 >> b;
        col = int'(posx) / 4;
        n.de   = de_in;
        n.b    = b;
        n.k    = col % ppb;
        n.addr = ((int'(posy) / 4) * 256 + col / ppb) % 65536;
        if (de_in) begin
          exp_rd = (!m_lv) || (n.addr != m_addr);
          m_addr = n.addr;
          m_lv   = 1'b1;
        end else begin
          exp_rd = 1'b0;
          m_lv   = 1'b0;
        end
        exp_addr = AW'(m_addr);
        mq.push_back(n);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && chk_en) begin
        checkOutput("cmp_m_pixel",  32'(m_pixel),     32'(exp_pix));
        checkOutput("cmp_de_out",   32'(de_out),      32'(exp_de));
        checkOutput("cmp_rd_en",    32'(fb.rd_en),    32'(exp_rd));
        checkOutput("cmp_scr_addr", 32'(fb.scr_addr), 32'(exp_addr));
      end
    end
  end

  task automatic applyStimulus(input int x, input int y, input bit de, input int bpp);
    @(posedge clk);
    #1;
    posx    = 10'(x);
    posy    = 9'(y);
    de_in   = de;
    bpp_sel = 2'(bpp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b0, 0);
  endtask

  int sx [80];
  int sy [80];
  int sb [80];
  bit sd [80];
  int erd [80];
  int eaddr [80];
  int epix [80];

  task automatic setPix(input int i, input int x, input int y, input bit d, input int b,
                        input int rd, input int addr, input int pix);
    sx[i] = x; sy[i] = y; sd[i] = d; sb[i] = b;
    erd[i] = rd; eaddr[i] = addr; epix[i] = pix;
  endtask

  // Pixel i's read is visible one cycle later and its colour three cycles later.
  task automatic runSeq(input string tag, input int n);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) applyStimulus(sx[i], sy[i], sd[i], sb[i]);
      else       applyStimulus(0, 0, 1'b0, 0);
      @(negedge clk);
      if (i >= 1 && i <= n) begin
        checkOutput({tag, "_rd_en"},    32'(fb.rd_en),    32'(erd[i-1]));
        checkOutput({tag, "_scr_addr"}, 32'(fb.scr_addr), 32'(eaddr[i-1]));
      end
      if (i >= 3) begin
        checkOutput({tag, "_m_pixel"}, 32'(m_pixel), 32'(epix[i-3]));
        checkOutput({tag, "_de_out"},  32'(de_out),  32'(sd[i-3]));
      end
    end
  endtask

  initial begin
    int pat [4];
    pat[0] = 0; pat[1] = 5; pat[2] = 10; pat[3] = 15;
    rst_n = 1'b1; posx = '0; posy = '0; de_in = 1'b0; bpp_sel = '0;
    pal_we = 1'b0; pal_idx = '0; pal_data = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_m_pixel",  32'(m_pixel),     32'd0);
    checkOutput("rst_de_out",   32'(de_out),      32'd0);
    checkOutput("rst_rd_en",    32'(fb.rd_en),    32'd0);
    checkOutput("rst_scr_addr", 32'(fb.scr_addr), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    $display("[TB] palette ramp readback");
    mem[0] = 8'h70;
    setPix(0, 4, 0, 1'b1, 2, 1, 0, 7);
    runSeq("pal7", 1);
    idle(2);

    $display("[TB] 1bpp single pixel");
    mem[16'h0201] = 8'h02;
    setPix(0, 36, 8, 1'b1, 0, 1, 16'h0201, 15);
    runSeq("bpp1", 1);
    idle(2);

    $display("[TB] 2bpp run");
    for (int i = 0; i < 4; i++) mem[i] = 8'hE4;
    for (int i = 0; i < 64; i++) setPix(i, i, 0, 1'b1, 1, (i % 16 == 0) ? 1 : 0, i / 16, pat[(i % 16) / 4]);
    runSeq("bpp2", 64);
    idle(2);

    $display("[TB] 4bpp palette write");
    applyStimulus(0, 0, 1'b0, 0);
    pal_we = 1'b1; pal_idx = 4'd3; pal_data = 4'h9;
    applyStimulus(0, 0, 1'b0, 0);
    pal_we = 1'b0;
    mem[0] = 8'h30;
    idle(1);
    setPix(0, 4, 0, 1'b1, 2, 1, 0, 9);
    runSeq("pal_wr", 1);
    applyStimulus(4, 0, 1'b1, 2);
    applyStimulus(0, 0, 1'b0, 0);
    applyStimulus(0, 0, 1'b0, 0);
    pal_we = 1'b1; pal_idx = 4'd3; pal_data = 4'h1;
    applyStimulus(0, 0, 1'b0, 0);
    pal_we = 1'b0;
    @(negedge clk);
    checkOutput("pal_same_cycle", 32'(m_pixel), 32'h9);
    idle(1);
    setPix(0, 4, 0, 1'b1, 2, 1, 0, 1);
    runSeq("pal_new", 1);
    idle(2);

    $display("[TB] mode switch mid-line");
    mem[1] = 8'h05; mem[5] = 8'h70; mem[6] = 8'h0C;
    setPix(0, 32, 0, 1'b1, 0, 1, 1, 15);
    setPix(1, 36, 0, 1'b1, 0, 0, 1, 0);
    setPix(2, 40, 0, 1'b1, 0, 0, 1, 15);
    setPix(3, 44, 0, 1'b1, 2, 1, 5, 7);
    setPix(4, 48, 0, 1'b1, 2, 1, 6, 12);
    runSeq("mode", 5);
    idle(2);

    $display("[TB] line boundary");
    mem[0] = 8'h06;
    setPix(0, 0, 0, 1'b1, 0, 1, 0, 0);
    setPix(1, 4, 0, 1'b1, 0, 0, 0, 15);
    setPix(2, 0, 0, 1'b0, 0, 0, 0, 0);
    setPix(3, 8, 0, 1'b1, 0, 1, 0, 15);
    runSeq("line", 4);
    idle(2);

    $display("[TB] reset mid-line");
    mem[16'h0100] = 8'h33;
    applyStimulus(4, 4, 1'b1, 2);
    applyStimulus(4, 4, 1'b1, 2);
    applyStimulus(4, 4, 1'b1, 2);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_m_pixel", 32'(m_pixel), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_m_pixel",  32'(m_pixel),     32'd0);
    checkOutput("mid_rst_de_out",   32'(de_out),      32'd0);
    checkOutput("mid_rst_rd_en",    32'(fb.rd_en),    32'd0);
    checkOutput("mid_rst_scr_addr", 32'(fb.scr_addr), 32'd0);
    posx = '0; posy = '0; de_in = 1'b0; bpp_sel = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    setPix(0, 4, 4, 1'b1, 2, 1, 16'h0100, 3);
    runSeq("post_rst", 1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
